sdram_responder: RTL and testbench

Synthesizable SDRAM-side responder for the image-processing custom logic. It accepts the one-cycle `sdram_read_en` / `sdram_write_en` pulses, address and write data issued by the custom logic. It serves them from an on-chip word memory and returns read data with a fixed-latency `sdram_datareadvalid` pulse. It lets the top-level datapath be simulated and prototyped without the external SDRAM controller, and provides protocol-error flags and transaction counters for debug.

---
 rtl/sdram_responder_if.sv | 28 ++
 rtl/sdram_responder.sv | 82 ++++++++
 tb/tb_sdram_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// Bus between the custom logic (master) and the SDRAM responder (slave).
// Master drives the request pulses, the word address and the write data.
// Slave returns read data with a valid pulse, plus error flags and counters.
`timescale 1ns/1ps
interface sdram_responder_if;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        oob_error;
  logic        collision_error;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output sdram_read_en, sdram_write_en, address_sdram, writeData_sdram,
    input  data_sdram, sdram_datareadvalid, oob_error, collision_error,
           rd_count, wr_count
  );

  modport slave (
    input  sdram_read_en, sdram_write_en, address_sdram, writeData_sdram,
    output data_sdram, sdram_datareadvalid, oob_error, collision_error,
           rd_count, wr_count
  );
endinterface

// File: rtl/sdram_responder.sv
// On-chip stand-in for the external SDRAM: serves one-cycle read/write pulses
// from a word memory; read data returns READ_LATENCY cycles after the request
// edge; no backpressure, a request can be accepted on every cycle.
// Ports: clk, n_rst (async active-low), bus (slave side of sdram_responder_if:
// requests in; data_sdram/sdram_datareadvalid, sticky error flags, counters out).
`timescale 1ns/1ps
module sdram_responder #(
  parameter int          MEM_DEPTH_LOG2 = 10,
  parameter int          READ_LATENCY   = 2,
  parameter logic [31:0] OOB_DATA       = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               n_rst,
  sdram_responder_if.slave   bus
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic                      in_range;
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic                      rd_accept;
  logic                      collide;

  logic [READ_LATENCY-1:0]   pipe_vld;
  logic [31:0]               pipe_dat [READ_LATENCY];

  // Upper address bits are never wrapped: any set bit above the memory
  // index makes the access out of range.
  assign in_range  = (bus.address_sdram >> MEM_DEPTH_LOG2) == 26'd0;
  assign idx       = bus.address_sdram[MEM_DEPTH_LOG2-1:0];
  // A read that collides with a write is discarded; the write still happens.
  assign rd_accept = bus.sdram_read_en && !bus.sdram_write_en;
  assign collide   = bus.sdram_read_en && bus.sdram_write_en;

  // Memory contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (bus.sdram_write_en && in_range)
      mem[idx] <= bus.writeData_sdram;
  end

  // Pipeline data needs no reset; only the valid bits qualify it.
  // Stage 0 reads the pre-edge memory, so a write on the previous edge is seen.
  always_ff @(posedge clk) begin
    pipe_dat[0] <= in_range ? mem[idx] : OOB_DATA;
    for (int i = 1; i < READ_LATENCY; i++)
      pipe_dat[i] <= pipe_dat[i-1];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pipe_vld                <= '0;
      bus.data_sdram          <= 32'd0;
      bus.sdram_datareadvalid <= 1'b0;
      bus.oob_error           <= 1'b0;
      bus.collision_error     <= 1'b0;
      bus.rd_count            <= 16'd0;
      bus.wr_count            <= 16'd0;
    end else begin
      pipe_vld[0] <= rd_accept;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_vld[i] <= pipe_vld[i-1];

      // Output register is the last of READ_LATENCY edges; data holds between pulses.
      bus.sdram_datareadvalid <= pipe_vld[READ_LATENCY-1];
      if (pipe_vld[READ_LATENCY-1])
        bus.data_sdram <= pipe_dat[READ_LATENCY-1];

      if ((bus.sdram_read_en || bus.sdram_write_en) && !in_range)
        bus.oob_error <= 1'b1;
      if (collide)
        bus.collision_error <= 1'b1;

      if (rd_accept)
        bus.rd_count <= bus.rd_count + 16'd1;
      if (bus.sdram_write_en)
        bus.wr_count <= bus.wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench: three responders (READ_LATENCY 1, 2, 8) driven in lockstep;
// expected read data and arrival cycle are queued per instance when a read is
// issued and popped when its valid pulse appears.
`timescale 1ns/1ps
module tb_sdram_responder;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  sdram_responder_if i1 ();
  sdram_responder_if i2 ();
  sdram_responder_if i8 ();

  sdram_responder #(.READ_LATENCY(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(i1));
  sdram_responder #(.READ_LATENCY(2)) dut2 (.clk(clk), .n_rst(n_rst), .bus(i2));
  sdram_responder #(.READ_LATENCY(8)) dut8 (.clk(clk), .n_rst(n_rst), .bus(i8));

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t        q [3][$];
  int          lat [3] = '{1, 2, 8};
  logic [31:0] model [int];
  int          cyc  = 0;
  int          ncmp = 0;
  int          nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic mon(input int k, input logic vld, input logic [31:0] dat);
    exp_t e;
    if (vld === 1'b1) begin
      if (q[k].size() == 0) begin
        check($sformatf("spurious_valid_L%0d", lat[k]), {31'd0, vld}, 32'd0);
      end else begin
        e = q[k].pop_front();
        check($sformatf("read_data_L%0d", lat[k]), dat, e.dat);
        check($sformatf("arrival_cycle_L%0d", lat[k]), cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, i1.sdram_datareadvalid, i1.data_sdram);
    mon(1, i2.sdram_datareadvalid, i2.data_sdram);
    mon(2, i8.sdram_datareadvalid, i8.data_sdram);
  end

  task automatic set_inputs(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d);
    i1.sdram_read_en = rd; i1.sdram_write_en = wr; i1.address_sdram = a; i1.writeData_sdram = d;
    i2.sdram_read_en = rd; i2.sdram_write_en = wr; i2.address_sdram = a; i2.writeData_sdram = d;
    i8.sdram_read_en = rd; i8.sdram_write_en = wr; i8.address_sdram = a; i8.writeData_sdram = d;
  endtask

  // Drive one request for the coming edge and record its expected effect.
  task automatic drive(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d);
    logic [31:0] rdat;
    @(negedge clk);
    set_inputs(rd, wr, a, d);
    if (rd && !wr) begin
      rdat = (a < 26'd1024) ? model[int'(a)] : 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++)
        q[k].push_back('{due: cyc + 1 + lat[k], dat: rdat});
    end
    if (wr && a < 26'd1024)
      model[int'(a)] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 26'd0, 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain_pending", q[0].size() + q[1].size() + q[2].size(), 32'd0);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] rc, input logic [15:0] wc,
                         input logic oe, input logic ce);
    check({tag, "_rd_count_L1"}, i1.rd_count, rc);
    check({tag, "_wr_count_L1"}, i1.wr_count, wc);
    check({tag, "_oob_L1"}, i1.oob_error, oe);
    check({tag, "_coll_L1"}, i1.collision_error, ce);
    check({tag, "_rd_count_L2"}, i2.rd_count, rc);
    check({tag, "_wr_count_L2"}, i2.wr_count, wc);
    check({tag, "_oob_L2"}, i2.oob_error, oe);
    check({tag, "_coll_L2"}, i2.collision_error, ce);
    check({tag, "_rd_count_L8"}, i8.rd_count, rc);
    check({tag, "_wr_count_L8"}, i8.wr_count, wc);
    check({tag, "_oob_L8"}, i8.oob_error, oe);
    check({tag, "_coll_L8"}, i8.collision_error, ce);
  endtask

  task automatic chk_dat(input string tag, input logic vld, input logic [31:0] dat);
    check({tag, "_valid_L1"}, i1.sdram_datareadvalid, vld);
    check({tag, "_data_L1"}, i1.data_sdram, dat);
    check({tag, "_valid_L2"}, i2.sdram_datareadvalid, vld);
    check({tag, "_data_L2"}, i2.data_sdram, dat);
    check({tag, "_valid_L8"}, i8.sdram_datareadvalid, vld);
    check({tag, "_data_L8"}, i8.data_sdram, dat);
  endtask

  initial begin
    set_inputs(1'b0, 1'b0, 26'd0, 32'd0);
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 16'd0, 16'd0, 1'b0, 1'b0);
    chk_dat("reset", 1'b0, 32'd0);
    n_rst = 1'b1;

    // Back-to-back writes then back-to-back reads.
    drive(1'b0, 1'b1, 26'd0, 32'h1122_3344);
    drive(1'b0, 1'b1, 26'd1, 32'h5566_7788);
    drive(1'b1, 1'b0, 26'd0, 32'd0);
    drive(1'b1, 1'b0, 26'd1, 32'd0);
    idle(1);
    drain();
    chk_all("t1", 16'd2, 16'd2, 1'b0, 1'b0);

    // Read on the edge right after a write to the same address; data then holds.
    drive(1'b0, 1'b1, 26'd5, 32'hAABB_CCDD);
    drive(1'b1, 1'b0, 26'd5, 32'd0);
    idle(1);
    drain();
    idle(3);
    chk_dat("hold", 1'b0, 32'hAABB_CCDD);
    chk_all("t2", 16'd3, 16'd3, 1'b0, 1'b0);

    // Out-of-range: first address past the end, then a high address bit.
    drive(1'b1, 1'b0, 26'h000_0400, 32'd0);
    idle(1);
    drain();
    chk_all("t3a", 16'd4, 16'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 26'h000_0400, 32'h1234_5678);
    drive(1'b1, 1'b0, 26'd0, 32'd0);
    drive(1'b1, 1'b0, 26'h200_0000, 32'd0);
    idle(1);
    drain();
    chk_all("t3b", 16'd6, 16'd4, 1'b1, 1'b0);

    // Collision: write lands, read is dropped.
    drive(1'b1, 1'b1, 26'd3, 32'h0000_00FF);
    idle(10);
    chk_all("t4a", 16'd6, 16'd5, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 26'd3, 32'd0);
    idle(1);
    drain();
    chk_all("t4b", 16'd7, 16'd5, 1'b1, 1'b1);

    // Reset with reads in flight: they must never appear.
    drive(1'b1, 1'b0, 26'd5, 32'd0);
    drive(1'b1, 1'b0, 26'd5, 32'd0);
    drive(1'b1, 1'b0, 26'd5, 32'd0);
    @(negedge clk);
    #1;
    set_inputs(1'b0, 1'b0, 26'd0, 32'd0);
    n_rst = 1'b0;
    for (int k = 0; k < 3; k++) q[k].delete();
    #1;
    chk_all("midrst", 16'd0, 16'd0, 1'b0, 1'b0);
    chk_dat("midrst", 1'b0, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(12);
    drive(1'b1, 1'b0, 26'd5, 32'd0);
    idle(1);
    drain();
    chk_all("t5", 16'd1, 16'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
